// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   imm_src_e  : format select encoding (IMM_I .. IMM_RSV)
//   constants  : XLEN / tag / instruction field widths
//   imm_decode : combinational immediate assembly, always returns a XLEN_MAX-wide
//                sign- or zero-extended value; callers truncate to their XLEN.
package imm_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned XLEN_MAX      = 64;
  localparam int unsigned TAG_W_DEFAULT = 8;
  localparam int unsigned IMM_IN_W      = 25;  // instr[31:7]
  localparam int unsigned IMM_SRC_W     = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_RSV   = 3'b111
  } imm_src_e;

  // instr[k] here is original instruction bit k+7. Extending to XLEN_MAX and
  // truncating later is equivalent to extending straight to XLEN.
  function automatic logic [XLEN_MAX-1:0] imm_decode(input logic [IMM_IN_W-1:0] instr,
                                                     input logic [IMM_SRC_W-1:0] src,
                                                     input logic xlen64);
    logic [XLEN_MAX-1:0] imm;
    imm = '0;
    case (imm_src_e'(src))
      IMM_I:     imm = {{52{instr[24]}}, instr[24:13]};
      IMM_S:     imm = {{52{instr[24]}}, instr[24:18], instr[4:0]};
      IMM_B:     imm = {{51{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:     imm = {{32{instr[24]}}, instr[24:5], 12'h000};
      IMM_J:     imm = {{43{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14],
                        1'b0};
      IMM_Z:     imm = {59'd0, instr[12:8]};
      // RV64 shift amounts carry one extra bit
      IMM_SHAMT: imm = xlen64 ? {58'd0, instr[18:13]} : {59'd0, instr[17:13]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry FIFO skid buffer with a registered ready.
//   clk_i / rst_i       : clock, synchronous active-high reset
//   flush_i             : drop all held entries; a same-cycle push is ignored
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and payload
// in_ready_o comes straight from a flop, so a push while full is never possible;
// two entries still sustain one transfer per cycle.
module skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (count_q != 2'd0);
  // Empty buffer presents zeros so the idle/reset output is well defined.
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign push = in_valid_i & in_ready_q & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (flush_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= in_data_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshakes.
//   clk, rst (sync active-high), flush
//   in_valid/in_ready, imm_in (instr[31:7]), imm_src, tag_in : request side
//   out_valid/out_ready, imm_out, tag_out, illegal           : result side
// Decode is combinational into a 2-entry skid buffer; every output comes from
// buffer registers, so there is no combinational imm_in -> imm_out path.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_IN_W-1:0]  imm_in,
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_out,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 illegal
);

  localparam int unsigned PayloadW = XLEN + TAG_W + 1;

  logic [XLEN-1:0]     imm_dec;
  logic                ill_dec;
  logic [PayloadW-1:0] in_payload, out_payload;

  assign imm_dec    = XLEN'(imm_decode(imm_in, imm_src, XLEN == 64));
  assign ill_dec    = (imm_src == IMM_RSV);
  assign in_payload = {imm_dec, tag_in, ill_dec};

  skid_buf #(
    .Width(PayloadW)
  ) u_skid_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_payload)
  );

  assign {imm_out, tag_out, illegal} = out_payload;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 8, width of the sideband tag carried alongside each immediate.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-008 SHALL have port imm_in, input, 25, instruction bits [31:7]; imm_in[k] = instr[k+7].
REQ-009 SHALL have port imm_src, input, 3, format select.
REQ-010 SHALL have port tag_in, input, TAG_W, sideband passed through unchanged.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port imm_out, output, XLEN, extended immediate.
REQ-014 SHALL have port tag_out, output, TAG_W, tag of the presented result.
REQ-015 SHALL have port illegal, output, 1, presented result came from a reserved imm_src.

Function
REQ-016 SHALL decode imm_src as follows:
- 000 I: sext(in[24:13]).
- 001 S: sext({in[24:18], in[4:0]}).
- 010 B: sext({in[24], in[0], in[23:18], in[4:1], 1'b0}).
- 011 U: sext({in[24:5], 12'h000}).
- 100 J: sext({in[24], in[12:5], in[13], in[23:14], 1'b0}).
REQ-017 SHALL decode 101 Z (CSR zimm) as zext(in[12:8]).
REQ-018 SHALL decode 110 SHAMT as zext(in[17:13]) when XLEN=32 and zext(in[18:13]) when XLEN=64.
REQ-019 SHALL treat 111 as reserved: imm_out=0 and illegal=1 for that entry; illegal=0 for all other codes.
REQ-020 SHALL sign-extend from the MSB of each assembled field to the full XLEN.
REQ-021 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-022 SHALL register the result: one cycle from input transfer to out_valid; no combinational path from imm_in to imm_out.
REQ-023 SHALL buffer results in a 2-entry skid buffer, giving a sustained throughput of 1 result per cycle with out_ready held high.
REQ-024 SHALL drive in_ready from a register only: in_ready=1 iff fewer than 2 entries are held.
REQ-025 SHALL accept an input while full if an output transfer occurs in the same cycle, but only when in_ready was already 1.
REQ-026 SHALL hold imm_out, tag_out and illegal stable while out_valid=1 and out_ready=0.
REQ-027 SHALL deliver results in strict FIFO order.
REQ-028 SHALL, on flush, empty the buffer next cycle; any same-cycle input is dropped and any same-cycle output transfer still counts.
REQ-029 SHALL, when flush and rst are asserted together, follow rst.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set out_valid=0, in_ready=1, imm_out=0, tag_out=0, illegal=0 and the entry count to 0.
REQ-031 SHALL, on rst mid-stream, discard in-flight and buffered entries; no result from before reset reaches the output.

Structure
REQ-032 SHALL place the imm_src enum (IMM_I .. IMM_RSV) and the XLEN/field-width constants in the shared package imm_pkg.
REQ-033 SHALL implement the decode as a combinational function in imm_pkg.
REQ-034 SHALL instantiate one sub-module, skid_buf, parametrised by payload width (XLEN+TAG_W+1).

Verification
REQ-035 XLEN=32, single transfers, out_ready=1:
- I in=25'h0002000 -> 32'h00000001.
- I in=25'h1000000 -> FFFFF800.
- S in=25'h1F00FF5 -> FFFFFF95.
- B in=25'h0000FFE... per REQ-016; B in=1_000011_0000001111111_1111_0 -> FFFFF07E.
- J in=1_0000000000_0_00000000_11111 -> FFF00000.
Each result appears 1 cycle after acceptance.
REQ-036 XLEN=64: U in=25'h1FFFFE0 -> FFFFFFFF_FFFFF000; SHAMT in[18:13]=6'h3F -> 64'h3F; Z in[12:8]=5'h1F -> 64'h1F.
REQ-037 Code 111 with any imm_in -> imm_out=0, illegal=1, tag_out=tag_in.
REQ-038 Backpressure:
- Stream 4 tagged requests with out_ready=0.
- Required: in_ready drops after 2 accepted; outputs stay stable.
- Release out_ready: tags emerge in order 0,1, then 2,3, with no loss or duplication.
REQ-039 Flush with 2 entries held plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped input never appears.
REQ-040 rst asserted mid-stream -> next cycle all REQ-030 values hold, and no pre-reset tag is ever output.
